// File: rtl/serv_ctrl_w.sv
// serv_ctrl_w: W-bit-per-cycle PC update and instruction-fetch control for the bit-serial core.
// The PC lives in the ibus address register and is rotated W bits per beat; after 32/W beats
// of i_pc_en it holds the next PC (increment, jump target or trap vector).
module serv_ctrl_w #(
  parameter int unsigned W        = 1,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter bit          WITH_CSR = 1'b1,
  parameter bit          WITH_C   = 1'b0
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_pc_en,
  input  logic         i_iscomp,
  input  logic         i_jump,
  input  logic         i_jal_or_jalr,
  input  logic         i_utype,
  input  logic         i_pc_rel,
  input  logic         i_trap,
  input  logic [W-1:0] i_imm,
  input  logic [W-1:0] i_buf,
  input  logic [W-1:0] i_csr_pc,
  output logic [W-1:0] o_rd,
  output logic [W-1:0] o_bad_pc,
  output logic         o_last,
  output logic         o_misalign,
  output logic [31:0]  o_ibus_adr,
  output logic         o_ibus_cyc,
  input  logic         i_ibus_ack
);

  localparam int unsigned B  = 32 / W;
  localparam int unsigned BW = $clog2(B);

  typedef enum logic [1:0] {StFetch, StExec, StUpdate, StHold} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            carry_i_q, carry_i_d;
  logic            carry_t_q, carry_t_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     adr_q, adr_d;

  logic [31:0]     base;
  logic [31:0]     p;
  logic            comp;
  logic            trap_en;
  logic [W-1:0]    pc;
  logic [W-1:0]    inc_s;
  logic [W-1:0]    imm_m;
  logic [W-1:0]    lsb_mask;
  logic [W-1:0]    offset_a;
  logic [W-1:0]    offset_b;
  logic [W:0]      sum_i;
  logic [W:0]      sum_t;
  logic [W-1:0]    pc_plus_inc;
  logic [W-1:0]    target_al;
  logic [W-1:0]    new_s;
  logic            misaligned;

  // Per-beat datapath: increment and target adders plus new-PC / rd slice selection.
  always_comb begin
    inc_s    = '0;
    imm_m    = '0;
    p        = '0;
    base     = 32'(beat_q) * W;
    comp     = WITH_C && i_iscomp;
    trap_en  = WITH_CSR && i_trap;
    pc       = adr_q[W-1:0];
    for (int k = 0; k < int'(W); k++) begin
      p        = base + 32'(k);
      // INC is 2 or 4, so exactly one bit position of the 32-bit constant is set
      inc_s[k] = comp ? (p == 32'd1) : (p == 32'd2);
      // U-type immediates only contribute bits 31:12
      imm_m[k] = i_imm[k] && (p >= 32'd12);
    end
    lsb_mask = '1;
    if (beat_q == '0) lsb_mask[0] = 1'b0;

    sum_i       = {1'b0, pc} + {1'b0, inc_s} + {{W{1'b0}}, carry_i_q};
    pc_plus_inc = sum_i[W-1:0];

    offset_a  = i_pc_rel ? pc : '0;
    offset_b  = i_utype ? imm_m : i_buf;
    sum_t     = {1'b0, offset_a} + {1'b0, offset_b} + {{W{1'b0}}, carry_t_q};
    target_al = sum_t[W-1:0] & lsb_mask;

    if (trap_en)     new_s = i_csr_pc & lsb_mask;
    else if (i_jump) new_s = target_al;
    else             new_s = pc_plus_inc;

    o_rd     = (i_utype ? target_al : '0) | (i_jal_or_jalr ? pc_plus_inc : '0);
    o_bad_pc = target_al;
    o_last   = (beat_q == BW'(B - 1));
  end

  // Beat counter, carries and PC shift register next-state.
  always_comb begin
    beat_d    = beat_q;
    carry_i_d = 1'b0;
    carry_t_d = 1'b0;
    adr_d     = adr_q;
    if (i_pc_en) begin
      beat_d = beat_q + 1'b1;
      adr_d  = {new_s, adr_q[31:W]};
      // Carry out of bit 31 is dropped so a following burst starts clean
      if (!o_last) begin
        carry_i_d = sum_i[W];
        carry_t_d = sum_t[W];
      end
    end
    misaligned = adr_d[1] && !WITH_C;
  end

  // Fetch FSM: next state, misalign flag and bus request.
  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    o_ibus_cyc = 1'b0;
    unique case (state_q)
      StFetch: begin
        o_ibus_cyc = 1'b1;
        // A PC update abandons the outstanding fetch
        if (i_pc_en)         state_d = StUpdate;
        else if (i_ibus_ack) state_d = StExec;
      end
      StExec: begin
        if (i_pc_en) state_d = StUpdate;
      end
      StUpdate: begin
        if (i_pc_en && o_last) begin
          state_d    = misaligned ? StHold : StFetch;
          misalign_d = misaligned;
        end
      end
      StHold: begin
        if (i_pc_en) begin
          state_d    = StUpdate;
          misalign_d = 1'b0;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= StFetch;
      beat_q     <= '0;
      carry_i_q  <= 1'b0;
      carry_t_q  <= 1'b0;
      misalign_q <= 1'b0;
      adr_q      <= RESET_PC;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      carry_i_q  <= carry_i_d;
      carry_t_q  <= carry_t_d;
      misalign_q <= misalign_d;
      adr_q      <= adr_d;
    end
  end

  assign o_ibus_adr = adr_q;
  assign o_misalign = misalign_q;

endmodule
